conv_window_scheduler: RTL and testbench
========================================

# conv_window_scheduler

Sequencer that walks a convolution window over an input feature map stored row-major in line memory. It emits one input-pixel address per handshake beat, in the order the MAC datapath consumes operands. It is built from nested index counters of the SIMPLE_COUNTER style and sits between the layer controller (Start/Done) and the feature-map read port (Valid/Ready). Stride is 1 and there is no padding, so the output map is (ImgH-K+1) x (ImgW-K+1).

## Interface
- BITWIDTH, 10: width of ImgW, ImgH and the row/col indices.
- KWIDTH, 4: width of KSize and the kr/kc indices.
- ADDRWIDTH, 20: width of WSCHED_Addr.
- WSCHED_Clk  input  1  clock; all logic on its rising edge.
- WSCHED_Clr  input  1  asynchronous, active-low reset.
- WSCHED_Start  input  1  start request; sampled only in IDLE.
- WSCHED_ImgW  input  BITWIDTH  image width in pixels; latched on accepted Start.
- WSCHED_ImgH  input  BITWIDTH  image height in pixels; latched on accepted Start.
- WSCHED_KSize  input  KWIDTH  kernel size K; latched on accepted Start.
- WSCHED_Ready  input  1  downstream accepts the current address.
- WSCHED_Addr  output  ADDRWIDTH  pixel address.
- WSCHED_Valid  output  1  WSCHED_Addr is valid.
- WSCHED_WinLast  output  1  current beat is the last of its window (kr=kc=K-1).
- WSCHED_Busy  output  1  high in RUN and DONE.
- WSCHED_Done  output  1  one-cycle completion pulse.
- WSCHED_Err  output  1  one-cycle pulse for an illegal configuration.
- WSCHED_StallCnt  output  16  stall counter; exists only with WSCHED_STALL_CNT_EN.

## Operation
- States:
  - IDLE: Start with a legal config goes to RUN and latches the config. Start with an illegal config (K=0, K>ImgW or K>ImgH) pulses Err and stays in IDLE.
  - RUN: steps through all beats; after the final accepted beat goes to DONE.
  - DONE: Done=1 for exactly one cycle, then IDLE.
- Loop order, fastest first: kc, kr, col (0..ImgW-K), row (0..ImgH-K).
- Addr = (row+kr)*ImgW + col + kc, truncated mod 2^ADDRWIDTH.
  - Computed incrementally with adders: a row-base register and a window-row register advance by ImgW. No multiplier.
- A beat completes when Valid and Ready are both high; the indices advance only then.
- While Ready=0, Addr, WinLast and Valid hold stable. Valid never drops mid-RUN.
- Start in RUN or DONE is ignored. Config inputs are don't-care outside the Start cycle.
- Beat count = (ImgH-K+1)*(ImgW-K+1)*K*K.
- Reset value of every output is 0 (including StallCnt); state goes to IDLE. Reset asserted mid-RUN aborts the run, and no Done pulse follows.

## Timing
- Start accepted in cycle n: Valid=1 with Addr=0 from cycle n+1.
- Each beat is accepted in the cycle where Valid and Ready are both high; the next address is presented in the following cycle. With Ready held at 1, throughput is 1 beat/cycle.
- Final beat accepted in cycle m: Valid=0 and Done=1 in cycle m+1; Busy=0 from cycle m+2. A new Start is accepted from cycle m+2.
- Err is asserted the cycle after the illegal Start.
- WinLast is registered and aligned with its beat's Addr.

## Configuration
- WSCHED_STALL_CNT_EN defined:
  - WSCHED_StallCnt port exists.
  - Counts cycles in RUN with Valid=1 and Ready=0.
  - Clears on an accepted Start and on reset. Saturates at 16'hFFFF.
  - Holds its value after Done.
- Not defined: the port and the counter logic are absent. Behaviour is otherwise identical.

## Test plan
- ImgW=ImgH=4, K=3, Ready=1:
  - 36 beats.
  - First window addresses 0,1,2,4,5,6,8,9,10, with WinLast only on 10.
  - Last beat Addr=15.
  - Done pulses exactly 1 cycle after the 36th beat.
- Same config with Ready toggling 1,0,0,1 repeating: the address sequence is identical, and Addr/Valid are stable through every stall. With the macro enabled, StallCnt ends at 70 (35 Ready=1 slots x 2 stall cycles before beat 36).
- ImgW=ImgH=1, K=1:
  - Single beat with Addr=0 and WinLast=1.
  - Done in the next cycle.
- K=5, ImgW=4, ImgH=8: Err pulses one cycle; Valid, Busy and Done stay 0. A subsequent legal Start runs normally.
- Clr pulled low at beat 10 of the 4x4/K=3 run:
  - All outputs 0 asynchronously; no Done pulse.
  - A new Start restarts at Addr=0.
- Start held high through a run: exactly one run executes, and a new run starts 2 cycles after Done's cycle.

Source files
------------

// File: rtl/conv_window_scheduler.sv
// Convolution window address sequencer: walks a KxK window (stride 1, no padding) over a row-major map.
// Optional stall counter output is built only when WSCHED_STALL_CNT_EN is defined.
`timescale 1ns/1ps

// state  | meaning
// S_IDLE | waiting for Start; illegal config pulses Err
// S_RUN  | presenting addresses, advancing on each Valid&Ready beat
// S_DONE | one-cycle Done pulse, then back to S_IDLE
module conv_window_scheduler #(
    parameter int BITWIDTH  = 10,
    parameter int KWIDTH    = 4,
    parameter int ADDRWIDTH = 20
) (
    input  logic                 WSCHED_Clk,
    input  logic                 WSCHED_Clr,
    input  logic                 WSCHED_Start,
    input  logic [BITWIDTH-1:0]  WSCHED_ImgW,
    input  logic [BITWIDTH-1:0]  WSCHED_ImgH,
    input  logic [KWIDTH-1:0]    WSCHED_KSize,
    input  logic                 WSCHED_Ready,
    output logic [ADDRWIDTH-1:0] WSCHED_Addr,
    output logic                 WSCHED_Valid,
    output logic                 WSCHED_WinLast,
    output logic                 WSCHED_Busy,
    output logic                 WSCHED_Done,
    output logic                 WSCHED_Err
`ifdef WSCHED_STALL_CNT_EN
  , output logic [15:0]          WSCHED_StallCnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state;
    logic [BITWIDTH-1:0]   img_w;
    logic [BITWIDTH-1:0]   img_h;
    logic [KWIDTH-1:0]     k_size;
    logic [KWIDTH-1:0]     kc, kr;
    logic [BITWIDTH-1:0]   col, row;
    logic [ADDRWIDTH-1:0]  row_base, win_row;

    logic [KWIDTH-1:0]     kc_n, kr_n, k_last;
    logic [BITWIDTH-1:0]   col_n, row_n, col_last, row_last;
    logic [ADDRWIDTH-1:0]  row_base_n, win_row_n, addr_n, w_ext, col_ext;
    logic                  final_beat, win_last_n, cfg_bad, beat;

    assign cfg_bad  = (WSCHED_KSize == '0)
                   || (BITWIDTH'(WSCHED_KSize) > WSCHED_ImgW)
                   || (BITWIDTH'(WSCHED_KSize) > WSCHED_ImgH);
    assign k_last   = k_size - 1'b1;
    assign col_last = img_w - BITWIDTH'(k_size);
    assign row_last = img_h - BITWIDTH'(k_size);
    assign w_ext    = ADDRWIDTH'(img_w);
    assign col_ext  = ADDRWIDTH'(col);
    assign beat     = (state == S_RUN) && WSCHED_Valid && WSCHED_Ready;

    // Next indices and address; row_base = row*W, win_row = (row+kr)*W, kept by adding W.
    always_comb begin
        kc_n       = kc;
        kr_n       = kr;
        col_n      = col;
        row_n      = row;
        row_base_n = row_base;
        win_row_n  = win_row;
        addr_n     = WSCHED_Addr;
        final_beat = 1'b0;
        if (kc != k_last) begin
            kc_n   = kc + 1'b1;
            addr_n = WSCHED_Addr + 1'b1;
        end else if (kr != k_last) begin
            kc_n      = '0;
            kr_n      = kr + 1'b1;
            win_row_n = win_row + w_ext;
            addr_n    = win_row + w_ext + col_ext;
        end else if (col != col_last) begin
            kc_n      = '0;
            kr_n      = '0;
            col_n     = col + 1'b1;
            win_row_n = row_base;
            addr_n    = row_base + col_ext + 1'b1;
        end else if (row != row_last) begin
            kc_n       = '0;
            kr_n       = '0;
            col_n      = '0;
            row_n      = row + 1'b1;
            row_base_n = row_base + w_ext;
            win_row_n  = row_base + w_ext;
            addr_n     = row_base + w_ext;
        end else begin
            final_beat = 1'b1;
        end
        win_last_n = (kc_n == k_last) && (kr_n == k_last);
    end

    always_ff @(posedge WSCHED_Clk or negedge WSCHED_Clr) begin
        if (!WSCHED_Clr) begin
            state           <= S_IDLE;
            img_w           <= '0;
            img_h           <= '0;
            k_size          <= '0;
            kc              <= '0;
            kr              <= '0;
            col             <= '0;
            row             <= '0;
            row_base        <= '0;
            win_row         <= '0;
            WSCHED_Addr     <= '0;
            WSCHED_Valid    <= 1'b0;
            WSCHED_WinLast  <= 1'b0;
            WSCHED_Busy     <= 1'b0;
            WSCHED_Done     <= 1'b0;
            WSCHED_Err      <= 1'b0;
`ifdef WSCHED_STALL_CNT_EN
            WSCHED_StallCnt <= '0;
`endif
        end else begin
            WSCHED_Done <= 1'b0;
            WSCHED_Err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (WSCHED_Start) begin
                        if (cfg_bad) begin
                            WSCHED_Err <= 1'b1;
                        end else begin
                            state          <= S_RUN;
                            img_w          <= WSCHED_ImgW;
                            img_h          <= WSCHED_ImgH;
                            k_size         <= WSCHED_KSize;
                            kc             <= '0;
                            kr             <= '0;
                            col            <= '0;
                            row            <= '0;
                            row_base       <= '0;
                            win_row        <= '0;
                            WSCHED_Addr    <= '0;
                            WSCHED_Valid   <= 1'b1;
                            WSCHED_WinLast <= (WSCHED_KSize == KWIDTH'(1));
                            WSCHED_Busy    <= 1'b1;
`ifdef WSCHED_STALL_CNT_EN
                            WSCHED_StallCnt <= '0;
`endif
                        end
                    end
                end
                S_RUN: begin
`ifdef WSCHED_STALL_CNT_EN
                    if (WSCHED_Valid && !WSCHED_Ready && (WSCHED_StallCnt != 16'hFFFF))
                        WSCHED_StallCnt <= WSCHED_StallCnt + 1'b1;
`endif
                    if (beat) begin
                        if (final_beat) begin
                            state          <= S_DONE;
                            WSCHED_Valid   <= 1'b0;
                            WSCHED_WinLast <= 1'b0;
                            WSCHED_Addr    <= '0;
                            WSCHED_Done    <= 1'b1;
                        end else begin
                            kc             <= kc_n;
                            kr             <= kr_n;
                            col            <= col_n;
                            row            <= row_n;
                            row_base       <= row_base_n;
                            win_row        <= win_row_n;
                            WSCHED_Addr    <= addr_n;
                            WSCHED_WinLast <= win_last_n;
                        end
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    WSCHED_Busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler; expected addresses come from a nested-loop reference model.
`timescale 1ns/1ps

module tb_conv_window_scheduler;
    localparam int BW = 10;
    localparam int KW = 4;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic [BW-1:0] img_w = '0;
    logic [BW-1:0] img_h = '0;
    logic [KW-1:0] ksize = '0;
    logic [AW-1:0] addr;
    logic          valid, win_last, busy, done, err;
`ifdef WSCHED_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int total = 0;
    int passed = 0;
    int exp_addr[$];
    bit exp_wl[$];

    conv_window_scheduler #(.BITWIDTH(BW), .KWIDTH(KW), .ADDRWIDTH(AW)) dut (
        .WSCHED_Clk     (clk),
        .WSCHED_Clr     (clr),
        .WSCHED_Start   (start),
        .WSCHED_ImgW    (img_w),
        .WSCHED_ImgH    (img_h),
        .WSCHED_KSize   (ksize),
        .WSCHED_Ready   (ready),
        .WSCHED_Addr    (addr),
        .WSCHED_Valid   (valid),
        .WSCHED_WinLast (win_last),
        .WSCHED_Busy    (busy),
        .WSCHED_Done    (done),
        .WSCHED_Err     (err)
`ifdef WSCHED_STALL_CNT_EN
      , .WSCHED_StallCnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, 32'(addr), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_winlast"}, 32'(win_last), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    task automatic build_exp(input int w, input int h, input int k);
        exp_addr.delete();
        exp_wl.delete();
        for (int r = 0; r <= h - k; r++)
            for (int c = 0; c <= w - k; c++)
                for (int i = 0; i < k; i++)
                    for (int j = 0; j < k; j++) begin
                        exp_addr.push_back(((r + i) * w + c + j) % (1 << AW));
                        exp_wl.push_back((i == k - 1) && (j == k - 1));
                    end
    endtask

    // mode 0: Ready held high; mode 1: Ready high one cycle in three from the first Valid cycle.
    task automatic do_run(input int w, input int h, input int k, input int mode,
                          input bit hold, input int abort_at);
        int  n, beat, cyc;
        bit  aborted;
        build_exp(w, h, k);
        n = exp_addr.size();
        @(negedge clk);
        img_w = BW'(w);
        img_h = BW'(h);
        ksize = KW'(k);
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check("first_addr", 32'(addr), 0);
        beat = 0;
        cyc = 0;
        aborted = 0;
        while (beat < n && cyc < 3000) begin
            if (abort_at >= 0 && beat == abort_at) begin
                clr = 1'b0;
                #1;
                check_idle_outputs("abort");
                aborted = 1;
                break;
            end
            ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            check("valid_run", 32'(valid), 1);
            check("busy_run", 32'(busy), 1);
            check("addr", 32'(addr), 32'(exp_addr[beat]));
            if (ready) begin
                check("winlast", 32'(win_last), 32'(exp_wl[beat]));
                beat++;
            end
            cyc++;
            @(negedge clk);
        end
        if (aborted) begin
            repeat (2) @(negedge clk);
            clr = 1'b1;
            repeat (3) begin
                @(negedge clk);
                check("abort_no_done", 32'(done), 0);
                check("abort_idle_busy", 32'(busy), 0);
            end
            return;
        end
        check("beat_count", 32'(beat), 32'(n));
        check("done_pulse", 32'(done), 1);
        check("done_valid", 32'(valid), 0);
        check("done_busy", 32'(busy), 1);
`ifdef WSCHED_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), (mode == 0) ? 0 : 2 * (n - 1));
`endif
        @(negedge clk);
        check("post_done", 32'(done), 0);
        check("post_busy", 32'(busy), 0);
        check("post_valid", 32'(valid), 0);
`ifdef WSCHED_STALL_CNT_EN
        check("stall_hold", 32'(stall_cnt), (mode == 0) ? 0 : 2 * (n - 1));
`endif
        if (hold) begin
            @(negedge clk);
            start = 1'b0;
            check("restart_valid", 32'(valid), 1);
            check("restart_addr", 32'(addr), 0);
            check("restart_busy", 32'(busy), 1);
            clr = 1'b0;
            @(negedge clk);
            clr = 1'b1;
        end
    endtask

    initial begin
        clr = 1'b0;
        #12;
        check_idle_outputs("reset");
`ifdef WSCHED_STALL_CNT_EN
        check("reset_stall", 32'(stall_cnt), 0);
`endif
        @(negedge clk);
        clr = 1'b1;

        do_run(4, 4, 3, 0, 1'b0, -1);
        do_run(4, 4, 3, 1, 1'b0, -1);
        do_run(1, 1, 1, 0, 1'b0, -1);

        @(negedge clk);
        img_w = 10'd4;
        img_h = 10'd8;
        ksize = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 32'(err), 1);
        check("err_valid", 32'(valid), 0);
        check("err_busy", 32'(busy), 0);
        check("err_done", 32'(done), 0);
        @(negedge clk);
        check("err_clear", 32'(err), 0);
        check("err_idle_valid", 32'(valid), 0);
        check("err_idle_busy", 32'(busy), 0);

        do_run(5, 3, 2, 0, 1'b0, -1);
        do_run(4, 4, 3, 0, 1'b0, 10);
        do_run(4, 4, 3, 0, 1'b0, -1);
        do_run(4, 4, 3, 0, 1'b1, -1);
        do_run(6, 4, 3, 1, 1'b0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
